button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter NUM_BUTTONS, default 4: number of independent button channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default jzjcoref_io_pkg::DEFAULT_DEBOUNCE_CYCLES (500000 = 10 ms at 50 MHz): consecutive stable cycles required to accept a level.
REQ-003 SHALL have port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port rawButton, input, NUM_BUTTONS: asynchronous active-high button levels (already inverted from board pins).
REQ-006 SHALL have port debounced, output, NUM_BUTTONS: synchronized, debounced level per button.
REQ-007 SHALL have port pressPulse, output, NUM_BUTTONS: one-cycle strobe on an accepted 0->1 transition.
REQ-008 SHALL have port releasePulse, output, NUM_BUTTONS: one-cycle strobe on an accepted 1->0 transition.
REQ-009 SHALL have port pressLatched, output, NUM_BUTTONS: sticky press flag per button, for the MMIO input register.
REQ-010 SHALL have port clearLatched, input, NUM_BUTTONS: per-bit write-1-to-clear of pressLatched (driven from the MMIO output register).

Function
REQ-011 Each channel SHALL pass rawButton[i] through a two-flop synchronizer (sync1, sync2) before any other logic.
REQ-012 Each channel SHALL hold a counter of width $clog2(DEBOUNCE_CYCLES+1); counter clears to 0 on any cycle where sync2 == debounced.
REQ-013 When sync2 != debounced: if counter == DEBOUNCE_CYCLES-1, debounced SHALL toggle and counter SHALL clear; else counter SHALL increment by 1.
REQ-014 Latency: a raw change sampled into sync1 at edge N and held SHALL update debounced at edge N+1+DEBOUNCE_CYCLES.
REQ-015 A raw pulse or glitch shorter than DEBOUNCE_CYCLES cycles (as seen at sync2) SHALL leave debounced unchanged and the counter back at 0.
REQ-016 Counter SHALL never exceed DEBOUNCE_CYCLES-1; no wrap-around is possible.
REQ-017 pressPulse[i] SHALL be registered and high exactly for the first cycle in which debounced[i] reads 1; releasePulse[i] likewise for the first cycle debounced[i] reads 0 after a 1.
REQ-018 pressPulse and releasePulse for one channel SHALL never be high together.
REQ-019 pressLatched[i] SHALL be set at the edge where pressPulse[i] is driven high and cleared at an edge where clearLatched[i] is 1.
REQ-020 Simultaneous set and clearLatched on the same edge SHALL leave pressLatched set (a press is never lost).
REQ-021 Channels SHALL be fully independent; activity on one never affects another.
REQ-022 DEBOUNCE_CYCLES < 1 SHALL cause an elaboration-time error.

Reset
REQ-023 While reset is high at an edge: sync1, sync2, counters, debounced, pressPulse, releasePulse, pressLatched SHALL all become 0.
REQ-024 Reset mid-count SHALL discard the count; no pulse SHALL be emitted for a transition in progress.
REQ-025 A button held through reset SHALL be accepted after release as a new press: debounced rises at edge 1+DEBOUNCE_CYCLES after the first non-reset sampling edge, with pressPulse.

Structure
REQ-026 Package jzjcoref_io_pkg SHALL hold CLOCK_HZ (50000000) and DEFAULT_DEBOUNCE_CYCLES (500000).
REQ-027 Per-channel logic SHALL be sub-module button_debounce_channel (sync, counter, debounced, pulses, latch), instantiated NUM_BUTTONS times by generate.
REQ-028 Top-level wiring: rawButton from inverted pins; pressLatched/debounced to mmioInputs[4]; clearLatched from mmioOutputs[4].

Verification (DEBOUNCE_CYCLES=4, NUM_BUTTONS=4)
REQ-029 Clean press: rawButton[0] 0->1 sampled at edge 10, held -> debounced[0]=1 from edge 15, pressPulse[0] high one cycle at edge 15, pressLatched[0]=1 thereafter.
REQ-030 Bounce: rawButton[1] toggles 1,0,1,0 every 2 cycles then holds 1 -> exactly one pressPulse[1], no releasePulse[1], debounced[1] rises 5 edges after final stable sample.
REQ-031 Glitch: rawButton[2] high for 3 cycles -> debounced[2], pressPulse[2], pressLatched[2] stay 0.
REQ-032 Clear race: clearLatched[0]=1 on the same edge pressPulse[0] rises -> pressLatched[0]=1; clearLatched[0]=1 one edge later -> pressLatched[0]=0.
REQ-033 Reset mid-count: rawButton[3]=1 for 3 cycles, reset one cycle, rawButton[3] still 1 -> all outputs 0 after reset; pressPulse[3] at edge 1+4 after first post-reset sample.
REQ-034 Release: after REQ-029, rawButton[0] 1->0 held -> releasePulse[0] one cycle 5 edges later, pressLatched[0] unchanged.

Source files
------------

// File: rtl/jzjcoref_io_pkg.sv
// Shared constants for the board I/O blocks: system clock rate and the
// default button debounce interval derived from it.
package jzjcoref_io_pkg;

    localparam int CLOCK_HZ                = 50_000_000;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500_000;   // 10 ms at CLOCK_HZ

    // The counter only ever holds 0 .. cycles-1.
    // Never returns less than 1, so a bad parameter reaches the elaboration
    // check instead of producing a zero-width vector.
    function automatic int counter_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/button_debounce_channel.sv
// One button channel: two-flop synchronizer, stability counter, debounced
// level, press/release strobes and a sticky write-1-to-clear press flag.
module button_debounce_channel
    import jzjcoref_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_button,
    input  logic clear_latched,
    output logic debounced,
    output logic press_pulse,
    output logic release_pulse,
    output logic press_latched
);

    localparam int CW = counter_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("button_debounce_channel: DEBOUNCE_CYCLES must be at least 1");
    end

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] count;
    logic          differs;
    logic          accept;
    logic          rise;

    // A new level is accepted once it has differed for DEBOUNCE_CYCLES samples.
    assign differs = (sync2 != debounced);
    assign accept  = differs && (count == LAST_COUNT);
    assign rise    = accept && !debounced;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1         <= 1'b0;
            sync2         <= 1'b0;
            count         <= '0;
            debounced     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            press_latched <= 1'b0;
        end else begin
            sync1 <= raw_button;
            sync2 <= sync1;

            if (!differs || accept) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end

            if (accept) begin
                debounced <= ~debounced;
            end

            press_pulse   <= rise;
            release_pulse <= accept && debounced;
            // Set wins over clear so a press landing with a clear is kept.
            press_latched <= rise || (press_latched && !clear_latched);
        end
    end

    a_count_bounded: assert property (@(posedge clock) count <= LAST_COUNT);
    a_pulses_exclusive: assert property (@(posedge clock) !(press_pulse && release_pulse));

endmodule

// File: rtl/button_conditioner.sv
// Conditions NUM_BUTTONS asynchronous button levels into synchronized,
// debounced levels with press/release strobes and sticky press flags.
module button_conditioner
    import jzjcoref_io_pkg::*;
#(
    parameter int NUM_BUTTONS     = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] rawButton,
    input  logic [NUM_BUTTONS-1:0] clearLatched,
    output logic [NUM_BUTTONS-1:0] debounced,
    output logic [NUM_BUTTONS-1:0] pressPulse,
    output logic [NUM_BUTTONS-1:0] releasePulse,
    output logic [NUM_BUTTONS-1:0] pressLatched
);

    if (NUM_BUTTONS < 1) begin : g_bad_count
        $error("button_conditioner: NUM_BUTTONS must be at least 1");
    end

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_channel
        button_debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_channel (
            .clock        (clock),
            .reset        (reset),
            .raw_button   (rawButton[i]),
            .clear_latched(clearLatched[i]),
            .debounced    (debounced[i]),
            .press_pulse  (pressPulse[i]),
            .release_pulse(releasePulse[i]),
            .press_latched(pressLatched[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with DEBOUNCE_CYCLES=4, NUM_BUTTONS=4:
// directed scenarios plus a random run against a sliding-window reference model.
module tb_button_conditioner;

    localparam int NB = 4;
    localparam int DC = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic [NB-1:0] rawButton;
    logic [NB-1:0] clearLatched;
    logic [NB-1:0] debounced;
    logic [NB-1:0] pressPulse;
    logic [NB-1:0] releasePulse;
    logic [NB-1:0] pressLatched;

    int checks   = 0;
    int failures = 0;

    button_conditioner #(
        .NUM_BUTTONS    (NB),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rawButton   (rawButton),
        .clearLatched(clearLatched),
        .debounced   (debounced),
        .pressPulse  (pressPulse),
        .releasePulse(releasePulse),
        .pressLatched(pressLatched)
    );

    always #5 clock = ~clock;

    // Reference model: a level is accepted when the last DC synchronized
    // samples all differ from the current accepted level.
    logic [NB-1:0] m_s1 = '0, m_s2 = '0;
    logic [NB-1:0] m_deb = '0, m_press = '0, m_rel = '0, m_latch = '0;
    bit            hist [NB][$];

    task automatic step();
        @(posedge clock);
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_deb = '0;
            m_press = '0; m_rel = '0; m_latch = '0;
            for (int i = 0; i < NB; i++) hist[i].delete();
        end else begin
            for (int i = 0; i < NB; i++) begin
                bit ok;
                hist[i].push_back(m_s2[i]);
                if (hist[i].size() > DC) void'(hist[i].pop_front());
                ok = (hist[i].size() == DC);
                foreach (hist[i][k]) if (hist[i][k] == m_deb[i]) ok = 0;
                m_press[i] = ok && !m_deb[i];
                m_rel[i]   = ok && m_deb[i];
                m_latch[i] = m_press[i] || (m_latch[i] && !clearLatched[i]);
                if (ok) begin
                    m_deb[i] = ~m_deb[i];
                    hist[i].delete();
                end
            end
            m_s2 = m_s1;
            m_s1 = rawButton;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; rawButton = '0; clearLatched = '0;
        step(); step();
        reset = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_reset();
        reset = 1'b1; rawButton = 4'hF; clearLatched = '0;
        step(); step();
        if ({debounced, pressPulse, releasePulse, pressLatched} !== 16'h0) begin
            failures++;
            $display("FAIL reset_state got=%h exp=0000",
                     {debounced, pressPulse, releasePulse, pressLatched});
        end
        checks++;
        rawButton = '0;
        step();
        reset = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_clean_press();
        do_reset();
        rawButton[0] = 1'b1;
        step();
        for (int k = 1; k <= DC; k++) begin
            step();
            if ({debounced[0], pressPulse[0], pressLatched[0]} !== 3'b000) begin
                failures++;
                $display("FAIL clean_press_early edge+%0d got=%b exp=000", k,
                         {debounced[0], pressPulse[0], pressLatched[0]});
            end
            checks++;
        end
        step();
        if ({debounced[0], pressPulse[0], releasePulse[0], pressLatched[0]} !== 4'b1101) begin
            failures++;
            $display("FAIL clean_press_accept got=%b exp=1101",
                     {debounced[0], pressPulse[0], releasePulse[0], pressLatched[0]});
        end
        checks++;
        step();
        if ({debounced[0], pressPulse[0], pressLatched[0]} !== 3'b101) begin
            failures++;
            $display("FAIL clean_press_after got=%b exp=101",
                     {debounced[0], pressPulse[0], pressLatched[0]});
        end
        checks++;
    endtask

    task automatic test_release();
        rawButton[0] = 1'b0;
        step();
        for (int k = 1; k <= DC; k++) begin
            step();
            if ({debounced[0], releasePulse[0]} !== 2'b10) begin
                failures++;
                $display("FAIL release_early edge+%0d got=%b exp=10", k,
                         {debounced[0], releasePulse[0]});
            end
            checks++;
        end
        step();
        if ({debounced[0], pressPulse[0], releasePulse[0], pressLatched[0]} !== 4'b0011) begin
            failures++;
            $display("FAIL release_accept got=%b exp=0011",
                     {debounced[0], pressPulse[0], releasePulse[0], pressLatched[0]});
        end
        checks++;
        step();
        if ({releasePulse[0], pressLatched[0]} !== 2'b01) begin
            failures++;
            $display("FAIL release_after got=%b exp=01", {releasePulse[0], pressLatched[0]});
        end
        checks++;
    endtask

    task automatic test_bounce();
        int presses = 0, releases = 0, rise_at = -1;
        do_reset();
        for (int b = 0; b < 4; b++) begin
            rawButton[1] = (b % 2 == 0);
            repeat (2) begin
                step();
                presses += pressPulse[1]; releases += releasePulse[1];
            end
        end
        rawButton[1] = 1'b1;
        for (int k = 0; k < 15; k++) begin
            step();
            presses += pressPulse[1]; releases += releasePulse[1];
            if (debounced[1] && rise_at < 0) rise_at = k;
        end
        if (presses != 1 || releases != 0) begin
            failures++;
            $display("FAIL bounce_pulses got press=%0d release=%0d exp press=1 release=0",
                     presses, releases);
        end
        checks++;
        if (rise_at != DC + 1) begin
            failures++;
            $display("FAIL bounce_latency got=%0d exp=%0d", rise_at, DC + 1);
        end
        checks++;
    endtask

    task automatic test_glitch();
        logic [2:0] seen = '0;
        do_reset();
        rawButton[2] = 1'b1;
        repeat (DC - 1) begin
            step();
            seen |= {debounced[2], pressPulse[2], pressLatched[2]};
        end
        rawButton[2] = 1'b0;
        repeat (12) begin
            step();
            seen |= {debounced[2], pressPulse[2], pressLatched[2]};
        end
        if (seen !== 3'b000) begin
            failures++;
            $display("FAIL glitch_ignored got=%b exp=000", seen);
        end
        checks++;
    endtask

    task automatic test_clear_race();
        do_reset();
        rawButton[0] = 1'b1;
        step();
        repeat (DC) step();
        clearLatched[0] = 1'b1;
        step();
        if ({pressPulse[0], pressLatched[0]} !== 2'b11) begin
            failures++;
            $display("FAIL clear_race_set got=%b exp=11", {pressPulse[0], pressLatched[0]});
        end
        checks++;
        step();
        if ({pressPulse[0], pressLatched[0], debounced[0]} !== 3'b001) begin
            failures++;
            $display("FAIL clear_race_clear got=%b exp=001",
                     {pressPulse[0], pressLatched[0], debounced[0]});
        end
        checks++;
        clearLatched[0] = 1'b0;
        rawButton[0] = 1'b0;
        repeat (8) step();
    endtask

    task automatic test_reset_mid_count();
        int pulse_at = -1;
        do_reset();
        rawButton[3] = 1'b1;
        repeat (3) step();
        reset = 1'b1;
        step();
        if ({debounced, pressPulse, releasePulse, pressLatched} !== 16'h0) begin
            failures++;
            $display("FAIL midcount_reset got=%h exp=0000",
                     {debounced, pressPulse, releasePulse, pressLatched});
        end
        checks++;
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (pressPulse[3] && pulse_at < 0) pulse_at = k;
        end
        if (pulse_at != DC + 1) begin
            failures++;
            $display("FAIL midcount_press_latency got=%0d exp=%0d", pulse_at, DC + 1);
        end
        checks++;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NB; i++)
                if ($urandom_range(0, 7) == 0) rawButton[i] = ~rawButton[i];
            for (int i = 0; i < NB; i++)
                clearLatched[i] = ($urandom_range(0, 15) == 0);
            reset = ($urandom_range(0, 299) == 0);
            step();
            if ({debounced, pressPulse, releasePulse, pressLatched} !==
                {m_deb, m_press, m_rel, m_latch}) begin
                failures++;
                $display("FAIL random_cycle%0d got=%h exp=%h", c,
                         {debounced, pressPulse, releasePulse, pressLatched},
                         {m_deb, m_press, m_rel, m_latch});
            end
            checks++;
            if ((pressPulse & releasePulse) !== '0) begin
                failures++;
                $display("FAIL random_pulse_overlap cycle%0d got=%b exp=0000", c,
                         pressPulse & releasePulse);
            end
            checks++;
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rawButton = '0; clearLatched = '0;
        test_reset();
        test_clean_press();
        test_release();
        test_bounce();
        test_glitch();
        test_clear_race();
        test_reset_mid_count();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
